// File: rtl/opc6_bus_pkg.sv
// Shared types and constants for the opc6 CPU/DMA bus arbiter.
// The state encoding and the streak width are used by the top and the grant sub-module.
package opc6_bus_pkg;

  localparam int AW_DEF   = 16;
  localparam int DW_DEF   = 16;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ISSUE  = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } arb_state_t;

endpackage

// File: rtl/opc6_arb_grant.sv
// Starvation guard: counts CPU bus slots taken while DMA waits and decides DMA ownership of the slot.
// The streak saturates so a stuck request cannot wrap the counter back below CPU_BURST.
module opc6_arb_grant
  import opc6_bus_pkg::*;
#(
  parameter int CPU_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req,
  input  logic cpu_bus,
  input  logic slot_taken,
  input  logic dma_granted,
  output logic dma_win
);

  localparam logic [STREAK_W-1:0] BURST      = STREAK_W'(CPU_BURST);
  localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

  logic [STREAK_W-1:0] streak;

  assign dma_win = dma_req && (!cpu_bus || (streak >= BURST));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (dma_granted || !dma_req) begin
      streak <= '0;
    end else if (slot_taken && (streak != STREAK_MAX)) begin
      streak <= streak + 1'b1;
    end
  end

endmodule

// File: rtl/opc6_bus_arbiter.sv
// Shares one registered-read RAM and the IO bus between the opc6 CPU and a DMA requester,
// stalling the CPU via cpu_clken; CPU reads take two clocks, writes complete in the issue cycle.
module opc6_bus_arbiter
  import opc6_bus_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int CPU_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_vpa,
  input  logic          cpu_vda,
  input  logic          cpu_vio,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_address,
  input  logic [DW-1:0] cpu_dout,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_clken,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          io_en,
  output logic          io_we,
  output logic [AW-1:0] io_addr,
  output logic [DW-1:0] io_wdata,
  input  logic [DW-1:0] io_rdata
);

  arb_state_t state;
  logic       rd_vio;

  logic cpu_bus;
  logic cpu_mem_sel;
  logic in_issue;
  logic dma_win;
  logic dma_go;
  logic cpu_go;
  logic cpu_rd_go;

  // IO takes precedence if the CPU ever flags vio together with vpa/vda, so only one port is driven.
  assign cpu_bus     = cpu_vpa | cpu_vda | cpu_vio;
  assign cpu_mem_sel = (cpu_vpa | cpu_vda) & ~cpu_vio;
  assign in_issue    = (state == ISSUE) && !reset;
  assign dma_go      = in_issue && dma_win;
  assign cpu_go      = in_issue && !dma_win;
  assign cpu_rd_go   = cpu_go && cpu_bus && cpu_rnw;

  opc6_arb_grant #(
    .CPU_BURST (CPU_BURST)
  ) u_grant (
    .clk         (clk),
    .reset       (reset),
    .dma_req     (dma_req),
    .cpu_bus     (cpu_bus),
    .slot_taken  (cpu_go && cpu_bus),
    .dma_granted (dma_go),
    .dma_win     (dma_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ISSUE;
      rd_vio <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (dma_go && !dma_we) begin
            state <= DMA_RD;
          end else if (cpu_rd_go) begin
            state  <= CPU_RD;
            rd_vio <= cpu_vio;
          end
        end
        CPU_RD:  state <= ISSUE;
        DMA_RD:  state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

  // Bus strobes are combinational so CPU writes and DMA writes complete in the issue cycle itself.
  // NOTE: every output gets a default first so no path through this block can infer a latch.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = cpu_address;
    mem_wdata = cpu_dout;
    io_en     = 1'b0;
    io_we     = 1'b0;
    io_addr   = cpu_address;
    io_wdata  = cpu_dout;
    cpu_clken = 1'b0;
    cpu_din   = '0;
    dma_ack   = 1'b0;
    dma_rdata = '0;

    if (dma_go) begin
      mem_en    = 1'b1;
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      dma_ack   = dma_we;
    end else if (cpu_go) begin
      mem_en    = cpu_mem_sel;
      mem_we    = cpu_mem_sel && !cpu_rnw;
      io_en     = cpu_vio;
      io_we     = cpu_vio && !cpu_rnw;
      cpu_clken = !cpu_bus || !cpu_rnw;
    end

    if (!reset) begin
      if (state == CPU_RD) begin
        cpu_clken = 1'b1;
        cpu_din   = rd_vio ? io_rdata : mem_rdata;
      end
      if (state == DMA_RD) begin
        dma_ack   = 1'b1;
        dma_rdata = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_opc6_bus_arbiter.sv
// Directed bench for opc6_bus_arbiter with a behavioural registered-read RAM and IO device.
// Inputs change 1ns after the rising edge; outputs are checked 2ns after it.
module tb_opc6_bus_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_vpa, cpu_vda, cpu_vio, cpu_rnw;
  logic [AW-1:0] cpu_address;
  logic [DW-1:0] cpu_dout;
  logic [DW-1:0] cpu_din;
  logic          cpu_clken;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          io_en, io_we;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_wdata;
  logic [DW-1:0] io_rdata = '0;

  logic [DW-1:0] ram [0:65535];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  opc6_bus_arbiter #(
    .AW        (AW),
    .DW        (DW),
    .CPU_BURST (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_vpa     (cpu_vpa),
    .cpu_vda     (cpu_vda),
    .cpu_vio     (cpu_vio),
    .cpu_rnw     (cpu_rnw),
    .cpu_address (cpu_address),
    .cpu_dout    (cpu_dout),
    .cpu_din     (cpu_din),
    .cpu_clken   (cpu_clken),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ack     (dma_ack),
    .dma_rdata   (dma_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .io_en       (io_en),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata)
  );

  // RAM preload happens while reset is high so the array has a single writer process.
  always @(posedge clk) begin
    if (reset) begin
      ram[16'h0010] <= 16'h1234;
      ram[16'h0300] <= 16'hCAFE;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (io_en && !io_we) io_rdata <= 16'h00A5;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic vpa, input logic vda, input logic vio, input logic rnw,
                         input logic [AW-1:0] addr, input logic [DW-1:0] dout);
    cpu_vpa     = vpa;
    cpu_vda     = vda;
    cpu_vio     = vio;
    cpu_rnw     = rnw;
    cpu_address = addr;
    cpu_dout    = dout;
    #1;
  endtask

  task automatic dma_set(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    dma_req   = req;
    dma_we    = we;
    dma_addr  = addr;
    dma_wdata = wdata;
  endtask

  initial begin
    reset = 1'b1;
    dma_set(1'b0, 1'b0, '0, '0);
    cpu_set(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, '0);
    step();
    step();
    check("rst_clken", cpu_clken, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_io_en", io_en, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_cpu_din", cpu_din, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    reset = 1'b0;
    cpu_set(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    check("idle_clken", cpu_clken, 1);
    check("idle_mem_en", mem_en, 0);
    step();

    // Instruction fetch: two clocks, data appears in the second.
    cpu_set(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, '0);
    check("fetch_issue_clken", cpu_clken, 0);
    check("fetch_mem_en", mem_en, 1);
    check("fetch_mem_we", mem_we, 0);
    check("fetch_mem_addr", mem_addr, 16'h0010);
    check("fetch_io_en", io_en, 0);
    step();
    check("fetch_rd_clken", cpu_clken, 1);
    check("fetch_din", cpu_din, 16'h1234);
    check("fetch_rd_mem_en", mem_en, 0);
    step();

    // Data write completes in the issue cycle, then read back.
    cpu_set(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'hBEEF);
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16'h0200);
    check("wr_mem_wdata", mem_wdata, 16'hBEEF);
    check("wr_clken", cpu_clken, 1);
    check("wr_io_en", io_en, 0);
    step();
    cpu_set(1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, '0);
    check("rdback_issue_clken", cpu_clken, 0);
    step();
    check("rdback_din", cpu_din, 16'hBEEF);
    check("rdback_clken", cpu_clken, 1);
    step();

    // IO read and IO write.
    cpu_set(1'b0, 1'b0, 1'b1, 1'b1, 16'h00FE, '0);
    check("io_rd_io_en", io_en, 1);
    check("io_rd_io_we", io_we, 0);
    check("io_rd_mem_en", mem_en, 0);
    check("io_rd_addr", io_addr, 16'h00FE);
    check("io_rd_issue_clken", cpu_clken, 0);
    step();
    check("io_rd_din", cpu_din, 16'h00A5);
    check("io_rd_clken", cpu_clken, 1);
    step();
    cpu_set(1'b0, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0042);
    check("io_wr_io_we", io_we, 1);
    check("io_wr_mem_we", mem_we, 0);
    check("io_wr_wdata", io_wdata, 16'h0042);
    check("io_wr_clken", cpu_clken, 1);
    step();

    // Streaming fetches with a DMA read pending: four CPU reads, then the DMA slot.
    dma_set(1'b1, 1'b0, 16'h0300, '0);
    cpu_set(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, '0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst%0d_issue_addr", i), mem_addr, 16'h0010);
      check($sformatf("burst%0d_issue_clken", i), cpu_clken, 0);
      check($sformatf("burst%0d_issue_ack", i), dma_ack, 0);
      step();
      check($sformatf("burst%0d_rd_din", i), cpu_din, 16'h1234);
      check($sformatf("burst%0d_rd_clken", i), cpu_clken, 1);
      step();
    end
    check("dma_rd_issue_addr", mem_addr, 16'h0300);
    check("dma_rd_issue_en", mem_en, 1);
    check("dma_rd_issue_we", mem_we, 0);
    check("dma_rd_issue_clken", cpu_clken, 0);
    check("dma_rd_issue_ack", dma_ack, 0);
    step();
    check("dma_rd_ack", dma_ack, 1);
    check("dma_rd_rdata", dma_rdata, 16'hCAFE);
    check("dma_rd_clken", cpu_clken, 0);
    check("dma_rd_mem_en", mem_en, 0);
    step();
    dma_set(1'b0, 1'b0, '0, '0);
    #1;
    check("resume_addr", mem_addr, 16'h0010);
    check("resume_ack", dma_ack, 0);
    step();
    check("resume_din", cpu_din, 16'h1234);
    step();

    // Internal CPU cycle: DMA write is granted and acknowledged at once.
    cpu_set(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    dma_set(1'b1, 1'b1, 16'h0040, 16'h5555);
    #1;
    check("dma_wr_ack", dma_ack, 1);
    check("dma_wr_mem_we", mem_we, 1);
    check("dma_wr_addr", mem_addr, 16'h0040);
    check("dma_wr_wdata", mem_wdata, 16'h5555);
    check("dma_wr_clken", cpu_clken, 0);
    step();

    // CPU write collides with a fresh DMA read: CPU first, DMA in the next issue cycle.
    dma_set(1'b1, 1'b0, 16'h0040, '0);
    cpu_set(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'h1111);
    check("clash_cpu_addr", mem_addr, 16'h0200);
    check("clash_cpu_we", mem_we, 1);
    check("clash_clken", cpu_clken, 1);
    check("clash_ack", dma_ack, 0);
    step();
    cpu_set(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    check("clash_dma_addr", mem_addr, 16'h0040);
    check("clash_dma_clken", cpu_clken, 0);
    step();
    check("clash_dma_ack", dma_ack, 1);
    check("clash_dma_rdata", dma_rdata, 16'h5555);
    step();
    dma_set(1'b0, 1'b0, '0, '0);

    // Reset during CPU_RD drops the read; the CPU re-issues it afterwards.
    cpu_set(1'b0, 1'b1, 1'b0, 1'b1, 16'h0200, '0);
    check("rstrd_issue_clken", cpu_clken, 0);
    step();
    reset = 1'b1;
    #1;
    check("rstrd_clken", cpu_clken, 0);
    check("rstrd_ack", dma_ack, 0);
    check("rstrd_din", cpu_din, 0);
    step();
    reset = 1'b0;
    #1;
    check("rstrd_reissue_clken", cpu_clken, 0);
    check("rstrd_reissue_en", mem_en, 1);
    check("rstrd_reissue_addr", mem_addr, 16'h0200);
    step();
    check("rstrd_reissue_din", cpu_din, 16'h1111);
    check("rstrd_reissue_rd_clken", cpu_clken, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
